neopixel_rx: RTL and testbench

- WS2812-style single-wire receiver/decoder: samples a NeoPixel data line, classifies high-pulse widths into bits, assembles MSB-first 24-bit pixel words and detects the latch (reset) gap as frame end.
- Sits beside the NeoPixel transmitter for loopback self-test, and on the DOUT of the last LED in a chain for stream monitoring.
- Decoded pixels leave through a valid/ready port feeding a FIFO or register readback.

---
 rtl/neopixel_rx.sv | 256 +++++++++++++++++++++++++
 tb/tb_neopixel_rx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_rx.sv
// neopixel_rx: WS2812-style single-wire decoder.
// Measures high-pulse widths on a synchronized copy of the data line,
// turns them into bits, packs MSB-first pixel words and recognises the
// long low latch gap as the end of a frame. Decoded words leave through
// a single-entry valid/ready register; words arriving while it is still
// occupied are dropped and flagged.
module neopixel_rx #(
  parameter int CounterWidth    = 16,
  parameter int NumBitsPerPixel = 24,
  parameter int MaxNumNeoPixel  = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic                              din_i,
  input  logic [CounterWidth-1:0]           thresh_i,
  input  logic [CounterWidth-1:0]           min_high_i,
  input  logic [CounterWidth-1:0]           max_high_i,
  input  logic [CounterWidth-1:0]           t_latch_i,
  output logic [NumBitsPerPixel-1:0]        pixel_o,
  output logic                              pixel_valid_o,
  input  logic                              pixel_ready_i,
  output logic                              frame_done_o,
  output logic [$clog2(MaxNumNeoPixel):0]   frame_len_o,
  output logic                              err_o,
  output logic                              overflow_o
);

  localparam int LenW    = $clog2(MaxNumNeoPixel) + 1;
  localparam int BitCntW = $clog2(NumBitsPerPixel + 1);

  localparam logic [BitCntW-1:0]      LastBit = BitCntW'(NumBitsPerPixel - 1);
  localparam logic [LenW-1:0]         PixMax  = LenW'(MaxNumNeoPixel);
  localparam logic [CounterWidth-1:0] CntOne  = CounterWidth'(1);
  localparam logic [CounterWidth-1:0] CntSat  = '1;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_e;

  // Synchronizer and edge history
  logic sync1_q, sync2_q, prev_q;

  // Decoder state
  state_e                     state_q, state_d;
  logic [CounterWidth-1:0]    cnt_q, cnt_d;
  logic [BitCntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [NumBitsPerPixel-2:0] shift_q, shift_d;
  logic [LenW-1:0]            pix_cnt_q, pix_cnt_d;

  // Output stage
  logic [NumBitsPerPixel-1:0] pixel_q, pixel_d;
  logic                       valid_q, valid_d;
  logic [LenW-1:0]            frame_len_q, frame_len_d;
  logic                       frame_done_q, frame_done_d;
  logic                       err_q, err_d;
  logic                       overflow_q, overflow_d;

  // Decoder-to-output-stage events (same cycle)
  logic word_load;
  logic frame_end;
  logic decode_err;

  // Derived combinational values
  logic                       line, rise, fall;
  logic [CounterWidth-1:0]    cnt_inc;
  logic [CounterWidth-1:0]    t_latch_eff;
  logic                       bit_val;
  logic [NumBitsPerPixel-1:0] word;
  logic [LenW-1:0]            pix_cnt_inc;

  assign line = sync2_q;
  assign rise = line & ~prev_q;
  assign fall = ~line & prev_q;

  // The counter sticks at all-ones so a very long stretch never wraps back
  // into a short-looking width.
  assign cnt_inc     = (cnt_q == CntSat) ? cnt_q : cnt_q + CntOne;
  assign t_latch_eff = (t_latch_i == '0) ? CntOne : t_latch_i;
  assign bit_val     = (cnt_q >= thresh_i);
  assign word        = {shift_q, bit_val};
  assign pix_cnt_inc = (pix_cnt_q == PixMax) ? pix_cnt_q : pix_cnt_q + LenW'(1);

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Decoder state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RESYNC;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // Decoder next-state: pulse-width measurement, bit classification, framing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pix_cnt_d  = pix_cnt_q;
    word_load  = 1'b0;
    frame_end  = 1'b0;
    decode_err = 1'b0;

    if (!en_i) begin
      // Disabled: drop any partial word and wait for a fresh latch gap.
      state_d   = ST_RESYNC;
      cnt_d     = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RESYNC: begin
          // Only a full latch-length low stretch tells us where frames begin.
          if (line) begin
            cnt_d = '0;
          end else if (cnt_inc >= t_latch_eff) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_IDLE: begin
          if (rise) begin
            state_d   = ST_HIGH;
            cnt_d     = CntOne;
            bit_cnt_d = '0;
            pix_cnt_d = '0;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            if (cnt_q < min_high_i) begin
              decode_err = 1'b1;
              state_d    = ST_RESYNC;
              cnt_d      = '0;
              bit_cnt_d  = '0;
            end else begin
              shift_d = word[NumBitsPerPixel-2:0];
              state_d = ST_LOW;
              cnt_d   = CntOne;
              if (bit_cnt_q == LastBit) begin
                bit_cnt_d = '0;
                word_load = 1'b1;
                pix_cnt_d = pix_cnt_inc;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
          end else if (cnt_inc >= max_high_i) begin
            decode_err = 1'b1;
            state_d    = ST_RESYNC;
            cnt_d      = '0;
            bit_cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_LOW: begin
          if (rise) begin
            state_d = ST_HIGH;
            cnt_d   = CntOne;
          end else if (cnt_inc >= t_latch_eff) begin
            frame_end = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d   = ST_RESYNC;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // Output stage next-state: single-entry holding register and event pulses
  always_comb begin
    pixel_d      = pixel_q;
    valid_d      = valid_q;
    overflow_d   = 1'b0;
    frame_done_d = frame_end;
    frame_len_d  = frame_end ? pix_cnt_q : frame_len_q;
    // A latch gap that cuts a word short is both a frame end and an error.
    err_d        = decode_err | (frame_end & (bit_cnt_q != '0));

    if (word_load) begin
      if (!valid_q || pixel_ready_i) begin
        pixel_d = word;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && pixel_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output stage register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pixel_q      <= '0;
      valid_q      <= 1'b0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pixel_q      <= pixel_d;
      valid_q      <= valid_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_valid_o = valid_q;
  assign frame_len_o   = frame_len_q;
  assign frame_done_o  = frame_done_q;
  assign err_o         = err_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// Bench for neopixel_rx: drives pulse trains on din_i and compares the
// decoded stream against a pulse-level reference model.
module tb_neopixel_rx;

  localparam int THR  = 30;
  localparam int MINH = 5;
  localparam int MAXH = 100;
  localparam int TL   = 2500;

  logic        clk = 1'b0;
  logic        rst_i, en_i, din_i, pixel_ready_i;
  logic [15:0] thresh_i, min_high_i, max_high_i, t_latch_i;
  logic [23:0] pixel_o;
  logic        pixel_valid_o, frame_done_o, err_o, overflow_o;
  logic [8:0]  frame_len_o;

  neopixel_rx dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .din_i         (din_i),
    .thresh_i      (thresh_i),
    .min_high_i    (min_high_i),
    .max_high_i    (max_high_i),
    .t_latch_i     (t_latch_i),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o),
    .pixel_ready_i (pixel_ready_i),
    .frame_done_o  (frame_done_o),
    .frame_len_o   (frame_len_o),
    .err_o         (err_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed events, sampled on the falling edge
  int mon_frames = 0, mon_errs = 0, mon_ovf = 0, mon_both = 0;
  logic [23:0] got_q[$];

  always @(negedge clk) begin
    if (frame_done_o) mon_frames <= mon_frames + 1;
    if (err_o) mon_errs <= mon_errs + 1;
    if (overflow_o) mon_ovf <= mon_ovf + 1;
    if (frame_done_o && err_o) mon_both <= mon_both + 1;
    if (pixel_valid_o && pixel_ready_i) got_q.push_back(pixel_o);
  end

  // Reference model: works on whole pulses (high width, low width)
  bit          m_synced, m_started, m_ready, m_held_valid;
  int          m_nbits, m_pix, m_err, m_frames, m_both, m_ovf, m_len;
  logic [23:0] m_word, m_held;
  logic [23:0] exp_q[$];
  int          s_frames, s_errs, s_ovf, s_both;

  task automatic m_clear();
    #1;
    m_err = 0; m_frames = 0; m_both = 0; m_ovf = 0;
    exp_q.delete();
    got_q.delete();
    s_frames = mon_frames; s_errs = mon_errs; s_ovf = mon_ovf; s_both = mon_both;
  endtask

  task automatic m_abort();
    m_synced = 0; m_started = 0; m_nbits = 0; m_pix = 0;
  endtask

  task automatic m_emit(logic [23:0] w);
    if (m_ready) exp_q.push_back(w);
    else if (!m_held_valid) begin m_held = w; m_held_valid = 1; end
    else m_ovf++;
  endtask

  task automatic m_set_ready(bit r);
    if (r && m_held_valid) begin exp_q.push_back(m_held); m_held_valid = 0; end
    m_ready = r;
    pixel_ready_i = r;
  endtask

  task automatic m_high(int h);
    if (!m_synced) return;
    if (!m_started) begin m_started = 1; m_nbits = 0; m_pix = 0; end
    if (h >= MAXH || h < MINH) begin
      m_err++;
      m_abort();
      return;
    end
    m_word = {m_word[22:0], (h >= THR)};
    m_nbits++;
    if (m_nbits == 24) begin
      m_nbits = 0;
      if (m_pix < 256) m_pix++;
      m_emit(m_word);
    end
  endtask

  task automatic m_low(int l);
    if (l < TL) return;
    if (!m_synced) m_synced = 1;
    else if (m_started) begin
      m_frames++;
      m_len = m_pix;
      if (m_nbits != 0) begin m_err++; m_both++; end
      m_started = 0; m_nbits = 0; m_pix = 0;
    end
  endtask

  // Line drivers (all changes on the falling edge)
  task automatic drive_pulse(int h, int l);
    din_i = 1'b1;
    repeat (h) @(negedge clk);
    din_i = 1'b0;
    repeat (l) @(negedge clk);
    m_high(h);
    m_low(l);
  endtask

  task automatic drive_low(int l);
    din_i = 1'b0;
    repeat (l) @(negedge clk);
    m_low(l);
  endtask

  task automatic send_bit(bit b, bit jit);
    int h, l;
    if (jit) begin
      h = b ? int'($urandom_range(60, 30)) : int'($urandom_range(29, 5));
      if ($urandom_range(15, 0) == 0) h = b ? 99 : 5;
      l = int'($urandom_range(50, 2));
    end else begin
      h = b ? 40 : 20;
      l = b ? 22 : 42;
    end
    drive_pulse(h, l);
  endtask

  task automatic send_pixel(logic [23:0] w, bit jit);
    for (int i = 23; i >= 0; i--) send_bit(w[i], jit);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1; din_i = 1'b0;
    thresh_i = 16'(THR); min_high_i = 16'(MINH); max_high_i = 16'(MAXH); t_latch_i = 16'(TL);
    m_ready = 1; pixel_ready_i = 1'b1; m_held_valid = 0; m_len = 0; m_word = '0;
    m_abort();
    repeat (4) @(negedge clk);
    checks++; if (pixel_o !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h expected 000000", pixel_o); end
    checks++; if (pixel_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pixel_valid_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done_o); end
    checks++; if (frame_len_o !== 9'd0) begin errors++; $display("FAIL reset_frame_len: got %0d expected 0", frame_len_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pixel();
    logic [23:0] w;
    int lat;
    w = 24'hA53CF0;
    m_clear();
    drive_low(2600);
    for (int i = 23; i >= 1; i--) send_bit(w[i], 0);
    // Last bit (a zero): measure the fall-to-valid latency.
    din_i = 1'b1;
    repeat (20) @(negedge clk);
    din_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pixel_valid_o) begin lat = i; break; end
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", lat); end
    checks++; if (pixel_o !== 24'hA53CF0) begin errors++; $display("FAIL single_pixel: got %h expected a53cf0", pixel_o); end
    m_high(20);
    drive_low(2600);
    #1;
    checks++; if (mon_frames - s_frames !== m_frames) begin errors++; $display("FAIL single_frames: got %0d expected %0d", mon_frames - s_frames, m_frames); end
    checks++; if (frame_len_o !== 9'(m_len)) begin errors++; $display("FAIL single_len: got %0d expected %0d", frame_len_o, m_len); end
    checks++; if (mon_errs - s_errs !== m_err) begin errors++; $display("FAIL single_err: got %0d expected %0d", mon_errs - s_errs, m_err); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_three_pixels();
    m_clear();
    m_set_ready(1);
    send_pixel(24'h000001, 0);
    send_pixel(24'hFFFFFF, 0);
    send_pixel(24'h800000, 0);
    drive_low(2600);
    #1;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL three_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL three_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_len_o !== 9'(m_len)) begin errors++; $display("FAIL three_len: got %0d expected %0d", frame_len_o, m_len); end
    checks++; if (mon_ovf - s_ovf !== m_ovf) begin errors++; $display("FAIL three_ovf: got %0d expected %0d", mon_ovf - s_ovf, m_ovf); end
  endtask

  task automatic test_overflow();
    logic [23:0] a, b;
    a = 24'($urandom);
    b = 24'($urandom);
    m_clear();
    m_set_ready(0);
    send_pixel(a, 0);
    send_pixel(b, 0);
    drive_low(2600);
    #1;
    checks++; if (mon_ovf - s_ovf !== m_ovf) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", mon_ovf - s_ovf, m_ovf); end
    checks++; if (pixel_valid_o !== m_held_valid) begin errors++; $display("FAIL ovf_valid: got %b expected %b", pixel_valid_o, m_held_valid); end
    checks++; if (pixel_o !== m_held) begin errors++; $display("FAIL ovf_held: got %h expected %h", pixel_o, m_held); end
    checks++; if (frame_len_o !== 9'(m_len)) begin errors++; $display("FAIL ovf_len: got %0d expected %0d", frame_len_o, m_len); end
    @(negedge clk);
    m_set_ready(1);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_drain_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pixel_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid: got %b expected 0", pixel_valid_o); end
  endtask

  task automatic test_glitch();
    logic [23:0] a, b;
    a = 24'($urandom);
    b = 24'($urandom);
    m_clear();
    for (int i = 23; i >= 16; i--) send_bit(a[i], 0);
    drive_pulse(3, 40);
    for (int i = 15; i >= 0; i--) send_bit(a[i], 0);
    drive_low(2600);
    #1;
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_no_pixel: got %0d words expected 0", got_q.size()); end
    send_pixel(b, 0);
    drive_low(2600);
    #1;
    checks++; if (mon_errs - s_errs !== m_err) begin errors++; $display("FAIL glitch_err: got %0d expected %0d", mon_errs - s_errs, m_err); end
    checks++; if (mon_frames - s_frames !== m_frames) begin errors++; $display("FAIL glitch_frames: got %0d expected %0d", mon_frames - s_frames, m_frames); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_partial_frame();
    logic [23:0] a;
    a = 24'($urandom);
    m_clear();
    for (int i = 23; i >= 12; i--) send_bit(a[i], 0);
    drive_low(2600);
    #1;
    checks++; if (mon_both - s_both !== m_both) begin errors++; $display("FAIL partial_err_with_done: got %0d expected %0d", mon_both - s_both, m_both); end
    checks++; if (mon_errs - s_errs !== m_err) begin errors++; $display("FAIL partial_err: got %0d expected %0d", mon_errs - s_errs, m_err); end
    checks++; if (frame_len_o !== 9'(m_len)) begin errors++; $display("FAIL partial_len: got %0d expected %0d", frame_len_o, m_len); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL partial_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_stuck_high();
    logic [23:0] a, b;
    int lat;
    a = 24'($urandom);
    b = 24'($urandom);
    m_clear();
    for (int i = 23; i >= 19; i--) send_bit(a[i], 0);
    din_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (err_o && lat == 0) lat = i;
    end
    // Two synchronizer stages plus 100 high cycles, one more for the registered pulse.
    checks++; if (lat < 100 || lat > 102) begin errors++; $display("FAIL stuck_err_time: got %0d expected 100..102", lat); end
    m_high(120);
    drive_low(2600);
    send_pixel(b, 0);
    drive_low(2600);
    #1;
    checks++; if (mon_errs - s_errs !== m_err) begin errors++; $display("FAIL stuck_err: got %0d expected %0d", mon_errs - s_errs, m_err); end
    checks++; if (mon_frames - s_frames !== m_frames) begin errors++; $display("FAIL stuck_frames: got %0d expected %0d", mon_frames - s_frames, m_frames); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stuck_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stuck_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable();
    logic [23:0] a, b;
    a = 24'($urandom);
    b = 24'($urandom);
    m_clear();
    for (int i = 23; i >= 14; i--) send_bit(a[i], 0);
    en_i = 1'b0;
    m_abort();
    repeat (30) @(negedge clk);
    en_i = 1'b1;
    drive_low(2600);
    send_pixel(b, 0);
    drive_low(2600);
    #1;
    checks++; if (mon_errs - s_errs !== m_err) begin errors++; $display("FAIL enable_err: got %0d expected %0d", mon_errs - s_errs, m_err); end
    checks++; if (mon_frames - s_frames !== m_frames) begin errors++; $display("FAIL enable_frames: got %0d expected %0d", mon_frames - s_frames, m_frames); end
    checks++; if (frame_len_o !== 9'(m_len)) begin errors++; $display("FAIL enable_len: got %0d expected %0d", frame_len_o, m_len); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL enable_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL enable_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int npix;
    m_clear();
    for (int f = 0; f < 3; f++) begin
      npix = int'($urandom_range(2, 1));
      for (int p = 0; p < npix; p++) send_pixel(24'($urandom), 1);
      drive_low(2600);
    end
    #1;
    checks++; if (mon_frames - s_frames !== m_frames) begin errors++; $display("FAIL random_frames: got %0d expected %0d", mon_frames - s_frames, m_frames); end
    checks++; if (mon_errs - s_errs !== m_err) begin errors++; $display("FAIL random_err: got %0d expected %0d", mon_errs - s_errs, m_err); end
    checks++; if (frame_len_o !== 9'(m_len)) begin errors++; $display("FAIL random_len: got %0d expected %0d", frame_len_o, m_len); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_three_pixels();
    test_overflow();
    test_glitch();
    test_partial_frame();
    test_stuck_high();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
